// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage driven by the 3-bit alucontrol code.
// A valid/ready input handshake feeds a registered output register (M) backed by
// one skid register (S). in_ready depends only on S occupancy, so out_ready has no
// combinational path to in_ready.
// Optional macro ALU_OVF_EN: when defined, signed overflow for add/sub is computed
// and carried with each entry. When undefined, overflow is tied to 0.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             overflow
);

  // Entry layout: {result, zero, illegal[, overflow]}
`ifdef ALU_OVF_EN
  localparam int unsigned PW = WIDTH + 3;
`else
  localparam int unsigned PW = WIDTH + 2;
`endif

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_sub_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic             w_zero;
  logic [PW-1:0]    w_entry;
  logic             w_accept;
  logic             w_pop;

  logic             r_m_valid;
  logic             r_s_valid;
  logic [PW-1:0]    r_m_pl;
  logic [PW-1:0]    r_s_pl;

  assign w_sum  = srca + srcb;
  assign w_diff = srca - srcb;
  // slt takes the sign of a-b corrected by signed overflow, so it works across the
  // full signed range (e.g. 0x80000000 < 1).
  assign w_sub_ovf = (srca[WIDTH-1] ^ srcb[WIDTH-1]) & (w_diff[WIDTH-1] ^ srca[WIDTH-1]);
  assign w_slt     = w_diff[WIDTH-1] ^ w_sub_ovf;

`ifdef ALU_OVF_EN
  logic w_add_ovf;
  logic w_ovf;
  assign w_add_ovf = ~(srca[WIDTH-1] ^ srcb[WIDTH-1]) & (w_sum[WIDTH-1] ^ srca[WIDTH-1]);
`endif

  // Decode the operation; unknown or unassigned codes fall to the illegal default
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
`ifdef ALU_OVF_EN
    w_ovf = 1'b0;
`endif
    case (alucontrol)
      3'b010: begin
        w_res = w_sum;
`ifdef ALU_OVF_EN
        w_ovf = w_add_ovf;
`endif
      end
      3'b110: begin
        w_res = w_diff;
`ifdef ALU_OVF_EN
        w_ovf = w_sub_ovf;
`endif
      end
      3'b000:  w_res = srca & srcb;
      3'b001:  w_res = srca | srcb;
      3'b111:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_ill = 1'b1;
    endcase
  end

  assign w_zero = (w_res == '0);

`ifdef ALU_OVF_EN
  assign w_entry = {w_res, w_zero, w_ill, w_ovf};
`else
  assign w_entry = {w_res, w_zero, w_ill};
`endif

  assign w_accept = in_valid & ~r_s_valid;
  assign w_pop    = r_m_valid & out_ready;

  // M/S occupancy and payload update; reset beats flush, flush beats accept and pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_pl    <= '0;
      r_s_pl    <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (r_s_valid) begin
      // in_ready is low here, so only a drain from S into M can happen
      if (w_pop) begin
        r_m_pl    <= r_s_pl;
        r_s_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_m_valid || w_pop) begin
        r_m_pl    <= w_entry;
        r_m_valid <= 1'b1;
      end else begin
        r_s_pl    <= w_entry;
        r_s_valid <= 1'b1;
      end
    end else if (w_pop) begin
      r_m_valid <= 1'b0;
    end
  end

  assign in_ready  = ~r_s_valid;
  assign out_valid = r_m_valid;
  assign result    = r_m_pl[PW-1 -: WIDTH];
  assign zero      = r_m_pl[PW-WIDTH-1];
  assign illegal   = r_m_pl[PW-WIDTH-2];
`ifdef ALU_OVF_EN
  assign overflow  = r_m_pl[0];
`else
  assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed cases plus randomized traffic, checked by a
// scoreboard queue filled at accept time and drained by an independent monitor.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected entries in order: {result, zero, illegal, overflow}
  logic [34:0] sb[$];

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain signed/unsigned arithmetic on 64-bit integers
  function automatic logic [34:0] ref_model(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb_v;
    longint      r;
    logic [31:0] res;
    logic        ill;
    logic        ovf;
    sa   = $signed(a);
    sb_v = $signed(b);
    res  = 32'd0;
    ill  = 1'b0;
    ovf  = 1'b0;
    case (c)
      3'b010: begin
        r   = sa + sb_v;
        res = r[31:0];
        ovf = (r > MaxS) || (r < MinS);
      end
      3'b110: begin
        r   = sa - sb_v;
        res = r[31:0];
        ovf = (r > MaxS) || (r < MinS);
      end
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b111:  res = (sa < sb_v) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
`ifndef ALU_OVF_EN
    ovf = 1'b0;
`endif
    return {res, (res == 32'd0), ill, ovf};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: change inputs at negedge, sample 1 time unit later
  task automatic drive(input logic iv, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input logic fl,
                       input logic rs);
    @(negedge clk);
    in_valid   = iv;
    alucontrol = c;
    srca       = a;
    srcb       = b;
    out_ready  = ordy;
    flush      = fl;
    reset      = rs;
    #1;
    if (rs || fl) sb.delete();
    else if (iv && in_ready) sb.push_back(ref_model(c, a, b));
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 3'b000, 32'd0, 32'd0, ordy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every pop is compared against the oldest expected entry
  always @(negedge clk) begin
    #1;
    if (!reset && !flush && out_valid && out_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry",
                 {result, zero, illegal, overflow});
      end else begin
        logic [34:0] exp;
        exp = sb.pop_front();
        if ({result, zero, illegal, overflow} !== exp) begin
          n_fail++;
          $display("FAIL pop_payload: got 0x%0h expected 0x%0h",
                   {result, zero, illegal, overflow}, exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_ovf;
    in_valid   = 1'b0;
    alucontrol = 3'b000;
    srca       = 32'd0;
    srcb       = 32'd0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    reset      = 1'b1;

    // Reset state
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // add with signed overflow, 1-cycle latency
`ifdef ALU_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("add_latency_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'h8000_0000);
    check("add_zero", 64'(zero), 64'd0);
    check("add_overflow", 64'(overflow), 64'(exp_ovf));

    // slt across signed range
    drive(1'b1, 3'b111, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0);
    check("slt_neg2_result", 64'(result), 64'd1);
    drive(1'b1, 3'b111, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
    check("slt_min_result", 64'(result), 64'd1);
    idle(1'b1);
    check("slt_eq_result", 64'(result), 64'd0);
    check("slt_eq_zero", 64'(zero), 64'd1);
    idle(1'b1);

    // Stall: fill M and S, third op held upstream, then drain in order
    drive(1'b1, 3'b000, 32'hF0F0, 32'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'hF0, 32'h0F, 1'b0, 1'b0, 1'b0);
    check("stall_ready_after_1", 64'(in_ready), 64'd1);
    drive(1'b1, 3'b110, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    check("stall_ready_drop", 64'(in_ready), 64'd0);
    check("stall_head", 64'(result), 64'hF0);
    drive(1'b1, 3'b110, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
    check("stall_ready_still_low", 64'(in_ready), 64'd0);
    drive(1'b1, 3'b110, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
    check("stall_ready_back", 64'(in_ready), 64'd1);
    check("stall_second", 64'(result), 64'hFF);
    idle(1'b1);
    check("stall_third_zero", 64'(zero), 64'd1);
    idle(1'b1);
    check("stall_drained", 64'(out_valid), 64'd0);

    // Illegal code
    drive(1'b1, 3'b011, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("illegal_flag", 64'(illegal), 64'd1);
    check("illegal_result", 64'(result), 64'd0);
    idle(1'b1);

    // Flush with M and S full and an op presented
    drive(1'b1, 3'b010, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'd5, 32'd6, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);

    // Reset mid-stream with S full and downstream stalled
    drive(1'b1, 3'b001, 32'hAA, 32'h55, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_payload", 64'({result, zero, illegal, overflow}), 64'd0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, 3'($urandom_range(7)), rand_operand(), rand_operand(),
            $urandom_range(2) != 0, $urandom_range(63) == 0, $urandom_range(499) == 0);
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) idle(1'b1);
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
